key_command: RTL and testbench
==============================

KEY_COMMAND -- requirements
Module: key_command

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, consecutive equal samples required to accept a new key level (10 ms @ 50 MHz).
REQ-002 SHALL have parameter REPEAT_DELAY, default 15000000, hold cycles before the first auto-repeat.
REQ-003 SHALL have parameter REPEAT_PERIOD, default 5000000, hold cycles between subsequent auto-repeats.
REQ-004 SHALL have port clk  input  1  single system clock; all logic on posedge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have ports key_left_n, key_right_n, key_start_n  input  1 each  raw asynchronous push-buttons, 0 = pressed.
REQ-007 SHALL have ports left_moved, right_moved  input  1 each  move-complete acknowledges from the rocket stage.
REQ-008 SHALL have ports left, right  output  1 each  move commands to the rocket stage.
REQ-009 SHALL have port start  output  1  one-cycle start pulse.
REQ-010 SHALL have port busy  output  1  high whenever the FSM is not in S_IDLE.

Function
REQ-011 Each key SHALL pass through a 2-flop synchronizer, then a debouncer; the debounced level changes only after DEBOUNCE_CYCLES consecutive synchronized samples differ from it, and the counter clears on any sample equal to it.
REQ-012 A press event SHALL be the single cycle in which a debounced level goes 1->0.
REQ-013 start SHALL be high for exactly one cycle, the cycle after a start press event, regardless of FSM state.
REQ-014 FSM states SHALL be S_IDLE, S_LEFT, S_HOLD_L, S_RIGHT, S_HOLD_R.
REQ-015 S_IDLE: left press event -> S_LEFT; else right press event -> S_RIGHT; simultaneous events: left wins and the right event is discarded.
REQ-016 left SHALL be combinational: (state==S_LEFT) && !left_moved; right likewise with S_RIGHT and right_moved. Neither is ever high while its acknowledge is high.
REQ-017 S_LEFT: remain until left_moved==1, then -> S_HOLD_L; there is no timeout. S_RIGHT mirrors this with right_moved.
REQ-018 S_HOLD_L: left debounced released -> S_IDLE; right key events are ignored while in S_HOLD_L; S_HOLD_R mirrors this.
REQ-019 left and right SHALL never be high in the same cycle.
REQ-020 Repeat counter SHALL clear on entry to S_LEFT or S_RIGHT, and count only in the HOLD states.

Reset
REQ-021 While reset==0 at a clock edge: state=S_IDLE; left=right=start=busy=0; synchronizer and debounced levels =1 (released); all counters =0.
REQ-022 Reset mid-command SHALL abandon the command immediately; a key held through reset SHALL produce a press event DEBOUNCE_CYCLES+2 cycles after reset release.

Configuration
REQ-023 Macro KEY_COMMAND_AUTO_REPEAT_EN defined: in S_HOLD_L, when the count reaches REPEAT_DELAY (first repeat) or REPEAT_PERIOD (later repeats) with the key still held and left_moved==0 -> S_LEFT; if left_moved==1 the transition is held off until it drops; S_HOLD_R mirrors this.
REQ-024 Macro KEY_COMMAND_AUTO_REPEAT_EN undefined: repeat counter and logic SHALL be absent; the HOLD states exit only on release.

Structure
REQ-025 State encodings (3 bits) and default parameter values SHALL live in the shared game package/header used by the rocket stage.
REQ-026 Synchronizer plus debouncer SHALL be sub-module key_debounce (ports clk, reset, key_n, level, press), instantiated three times.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5)
REQ-027 Bounce key_left_n 0/1 every 2 cycles for 20 cycles, then release -> no press event, left never asserted.
REQ-028 Hold key_left_n=0 steadily; ack left_moved one cycle 8 cycles after left rises -> left high exactly until the ack cycle (low in the ack cycle); busy stays high until release.
REQ-029 Press left and right on the same cycle -> only left asserted; after ack and release of both -> S_IDLE with no right command.
REQ-030 With the macro defined, hold right 40 cycles with immediate acks -> repeat issues 10 then every 5 hold cycles; without the macro -> exactly one issue.
REQ-031 Assert reset during S_LEFT with the key held -> left=0 the next cycle; press event 6 cycles after reset release.
REQ-032 Press start -> start high exactly one cycle; holding start for 100 cycles -> no further pulse.

Source files
------------

// File: rtl/key_command_pkg.sv
// Shared game definitions: FSM state encodings and default timing values.
// Used by key_command, key_debounce and the rocket stage.
package key_command_pkg;

   localparam int unsigned DEBOUNCE_CYCLES_DEF = 500000;
   localparam int unsigned REPEAT_DELAY_DEF    = 15000000;
   localparam int unsigned REPEAT_PERIOD_DEF   = 5000000;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LEFT   = 3'd1,
      S_HOLD_L = 3'd2,
      S_RIGHT  = 3'd3,
      S_HOLD_R = 3'd4
   } state_t;

   // Bits needed to hold values 0..n.
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n + 1);
   endfunction

   function automatic int unsigned max_u(input int unsigned a,
                                         input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-flop synchronizer, then a debouncer.
// Ports: clk, reset (sync, active-low), key_n (raw, 0 = pressed),
//        level (debounced, 1 = released), press (one cycle on 1->0).
module key_debounce
   import key_command_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic key_n,
   output logic level,
   output logic press
);

   localparam int unsigned CW = cnt_w(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] cnt;

   // cnt holds how many consecutive synchronized samples have
   // disagreed with level; the D-th disagreeing sample flips it.
   always_ff @(posedge clk) begin
      if (!reset) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
         level <= 1'b1;
         press <= 1'b0;
         cnt   <= '0;
      end else begin
         sync1 <= key_n;
         sync2 <= sync1;
         press <= 1'b0;
         if (sync2 == level) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            level <= sync2;
            press <= ~sync2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/key_command.sv
// Turns left/right/start push-buttons into move commands and a start pulse.
// Ports: clk, reset (sync, active-low); key_left_n/key_right_n/key_start_n
//        raw buttons (0 = pressed); left_moved/right_moved acknowledges;
//        left/right move commands; start one-cycle pulse; busy (not idle).
// Macro KEY_COMMAND_AUTO_REPEAT_EN adds auto-repeat while a key is held.
module key_command
   import key_command_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
   parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic key_left_n,
   input  logic key_right_n,
   input  logic key_start_n,
   input  logic left_moved,
   input  logic right_moved,
   output logic left,
   output logic right,
   output logic start,
   output logic busy
);

   if (DEBOUNCE_CYCLES == 0 || REPEAT_DELAY == 0 || REPEAT_PERIOD == 0)
   begin : g_bad_cfg
      $error("key_command: cycle parameters must be nonzero");
   end

   state_t state;
   state_t state_nxt;

   logic level_l, press_l;
   logic level_r, press_r;
   logic level_s, press_s;
   logic start_q;
   logic rpt_go_l;
   logic rpt_go_r;

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_left (
      .clk   (clk),
      .reset (reset),
      .key_n (key_left_n),
      .level (level_l),
      .press (press_l)
   );

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_right (
      .clk   (clk),
      .reset (reset),
      .key_n (key_right_n),
      .level (level_r),
      .press (press_r)
   );

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start (
      .clk   (clk),
      .reset (reset),
      .key_n (key_start_n),
      .level (level_s),
      .press (press_s)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= S_IDLE;
         start_q <= 1'b0;
      end else begin
         state   <= state_nxt;
         // press already implies a low level; the qualifier is redundant
         start_q <= press_s & ~level_s;
      end
   end

`ifdef KEY_COMMAND_AUTO_REPEAT_EN
   localparam int unsigned RW = cnt_w(max_u(REPEAT_DELAY, REPEAT_PERIOD));

   logic [RW-1:0] rpt_cnt;
   logic [RW-1:0] rpt_target;
   logic          rpt_first;
   logic          rpt_hit;
   logic          in_hold;

   assign in_hold    = (state == S_HOLD_L) || (state == S_HOLD_R);
   assign rpt_target = rpt_first ? RW'(REPEAT_DELAY) : RW'(REPEAT_PERIOD);
   assign rpt_hit    = (rpt_cnt == rpt_target);
   assign rpt_go_l   = rpt_hit && !left_moved;
   assign rpt_go_r   = rpt_hit && !right_moved;

   // Counter saturates at the target so a held-off repeat
   // fires as soon as the acknowledge drops.
   always_ff @(posedge clk) begin
      if (!reset) begin
         rpt_cnt   <= '0;
         rpt_first <= 1'b1;
      end else begin
         if (state_nxt inside {S_LEFT, S_RIGHT}) begin
            rpt_cnt <= '0;
         end else if (in_hold && !rpt_hit) begin
            rpt_cnt <= rpt_cnt + RW'(1);
         end
         if (state == S_IDLE) begin
            rpt_first <= 1'b1;
         end else if (in_hold && (state_nxt inside {S_LEFT, S_RIGHT})) begin
            rpt_first <= 1'b0;
         end
      end
   end
`else
   assign rpt_go_l = 1'b0;
   assign rpt_go_r = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (press_l) begin
               state_nxt = S_LEFT;
            end else if (press_r) begin
               state_nxt = S_RIGHT;
            end
         end
         S_LEFT: begin
            if (left_moved) begin
               state_nxt = S_HOLD_L;
            end
         end
         S_HOLD_L: begin
            if (level_l) begin
               state_nxt = S_IDLE;
            end else if (rpt_go_l) begin
               state_nxt = S_LEFT;
            end
         end
         S_RIGHT: begin
            if (right_moved) begin
               state_nxt = S_HOLD_R;
            end
         end
         S_HOLD_R: begin
            if (level_r) begin
               state_nxt = S_IDLE;
            end else if (rpt_go_r) begin
               state_nxt = S_RIGHT;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign left  = (state == S_LEFT) && !left_moved;
   assign right = (state == S_RIGHT) && !right_moved;
   assign start = start_q;
   assign busy  = (state != S_IDLE);

endmodule

// File: tb/tb_key_command.sv
// Self-checking bench for key_command: behavioural model plus
// directed scenarios with literal expectations.
module tb_key_command;

   localparam int D  = 4;
   localparam int RD = 10;
   localparam int RP = 5;
`ifdef KEY_COMMAND_AUTO_REPEAT_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   localparam int M_IDLE = 0;
   localparam int M_CL   = 1;
   localparam int M_HL   = 2;
   localparam int M_CR   = 3;
   localparam int M_HR   = 4;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic kl = 1'b1;
   logic kr = 1'b1;
   logic ks = 1'b1;
   logic lm = 1'b0;
   logic rm = 1'b0;
   logic left, right, start, busy;

   always #5 clk = ~clk;

   key_command #(
      .DEBOUNCE_CYCLES(D),
      .REPEAT_DELAY   (RD),
      .REPEAT_PERIOD  (RP)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .key_left_n (kl),
      .key_right_n(kr),
      .key_start_n(ks),
      .left_moved (lm),
      .right_moved(rm),
      .left       (left),
      .right      (right),
      .start      (start),
      .busy       (busy)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Model: raw key history, a window rule for debouncing, and a
   // command mode tracker with a hold-age counter.
   bit hist [3][D+2];
   bit mlvl [3];
   bit mpress [3];
   bit raw [3];
   bit all_diff;
   int mode = M_IDLE;
   int age = 0;
   bit first = 1'b1;
   bit mstart = 1'b0;
   bit started = 1'b0;

   always @(posedge clk) begin
      started = 1'b1;
      raw[0] = kl;
      raw[1] = kr;
      raw[2] = ks;
      if (!reset) begin
         for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < D + 2; i++) hist[k][i] = 1'b1;
            mlvl[k] = 1'b1;
            mpress[k] = 1'b0;
         end
         mode = M_IDLE;
         age = 0;
         first = 1'b1;
         mstart = 1'b0;
      end else begin
         mstart = mpress[2];
         case (mode)
            M_IDLE: begin
               first = 1'b1;
               age = 0;
               if (mpress[0]) mode = M_CL;
               else if (mpress[1]) mode = M_CR;
            end
            M_CL: if (lm) mode = M_HL;
            M_CR: if (rm) mode = M_HR;
            M_HL: begin
               if (mlvl[0]) mode = M_IDLE;
               else if (AUTO && !lm && age >= (first ? RD : RP)) begin
                  mode = M_CL;
                  first = 1'b0;
                  age = 0;
               end else age++;
            end
            M_HR: begin
               if (mlvl[1]) mode = M_IDLE;
               else if (AUTO && !rm && age >= (first ? RD : RP)) begin
                  mode = M_CR;
                  first = 1'b0;
                  age = 0;
               end else age++;
            end
            default: mode = M_IDLE;
         endcase
         for (int k = 0; k < 3; k++) begin
            for (int i = D + 1; i > 0; i--) hist[k][i] = hist[k][i-1];
            hist[k][0] = raw[k];
            // level flips once the last D synchronized samples
            // (raw delayed by two edges) all disagree with it
            all_diff = 1'b1;
            for (int i = 2; i < D + 2; i++)
               if (hist[k][i] == mlvl[k]) all_diff = 1'b0;
            mpress[k] = 1'b0;
            if (all_diff) begin
               mlvl[k] = ~mlvl[k];
               mpress[k] = ~mlvl[k];
            end
         end
      end
   end

   int left_hi = 0;
   int right_hi = 0;
   int start_hi = 0;

   always @(negedge clk) begin
      if (started) begin
         chk("cyc_left", left, 32'((mode == M_CL) && !lm));
         chk("cyc_right", right, 32'((mode == M_CR) && !rm));
         chk("cyc_start", start, 32'(mstart));
         chk("cyc_busy", busy, 32'(mode != M_IDLE));
         chk("cyc_excl", 32'(left && right), 0);
         if (left === 1'b1) left_hi++;
         if (right === 1'b1) right_hi++;
         if (start === 1'b1) start_hi++;
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_left(output int n);
      n = 0;
      while (left !== 1'b1 && n < 50) begin
         step(1);
         n++;
      end
   endtask

   int n;
   int snap;
   int issues;
   bit prev_r;
   bit r;

   initial begin
      step(3);
      chk("rst_left", left, 0);
      chk("rst_start", start, 0);
      chk("rst_busy", busy, 0);
      reset = 1'b1;
      step(2);

      // bouncing left key: runs of 2 never debounce
      snap = left_hi;
      for (int i = 0; i < 10; i++) begin
         kl = (i % 2 == 0) ? 1'b0 : 1'b1;
         step(2);
      end
      kl = 1'b1;
      step(12);
      chk("bounce_left", left_hi - snap, 0);
      chk("bounce_busy", busy, 0);

      // steady hold, ack 8 cycles after left rises
      kl = 1'b0;
      wait_left(n);
      chk("press_latency", n, 7);
      snap = left_hi;
      step(8);
      lm = 1'b1;
      #1;
      chk("ack_cycle_left", left, 0);
      step(1);
      lm = 1'b0;
      chk("left_cycles", left_hi - snap, 8);
      chk("hold_busy", busy, 1);
      chk("hold_left", left, 0);
      kl = 1'b1;
      step(10);
      chk("release_busy", busy, 0);

      // simultaneous press: left wins
      snap = right_hi;
      kl = 1'b0;
      kr = 1'b0;
      wait_left(n);
      chk("simul_latency", n, 7);
      step(3);
      lm = 1'b1;
      step(1);
      lm = 1'b0;
      kl = 1'b1;
      kr = 1'b1;
      step(12);
      chk("simul_right", right_hi - snap, 0);
      chk("simul_busy", busy, 0);

      // right held 40 cycles with an immediate acknowledge
      issues = 0;
      prev_r = 1'b0;
      kr = 1'b0;
      for (int i = 0; i < 50; i++) begin
         step(1);
         rm = 1'b0;
         #1;
         r = right;
         if (r) rm = 1'b1;
         if (r && !prev_r) issues++;
         prev_r = r;
         if (i == 39) kr = 1'b1;
      end
      rm = 1'b0;
      step(2);
      chk("repeat_issues", issues, AUTO ? 5 : 1);
      chk("repeat_busy", busy, 0);

      // reset mid-command with the key still held
      kl = 1'b0;
      wait_left(n);
      chk("pre_rst_latency", n, 7);
      step(2);
      reset = 1'b0;
      step(1);
      chk("midrst_left", left, 0);
      chk("midrst_busy", busy, 0);
      step(1);
      reset = 1'b1;
      wait_left(n);
      chk("post_rst_latency", n, 7);
      lm = 1'b1;
      step(1);
      lm = 1'b0;
      kl = 1'b1;
      step(12);
      chk("post_rst_busy", busy, 0);

      // start held for 100 cycles
      snap = start_hi;
      ks = 1'b0;
      n = 0;
      while (start !== 1'b1 && n < 50) begin
         step(1);
         n++;
      end
      chk("start_latency", n, 7);
      step(100 - n);
      ks = 1'b1;
      step(10);
      chk("start_pulses", start_hi - snap, 1);
      chk("start_busy", busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

endmodule
